apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  APB requester: turns a simple valid/ready command stream into APB SETUP/ACCESS transfers and returns one response per command.
//  Sits between on-chip control logic (or a testbench sequencer) and the APB slave/register-file wrapper.
//  Supports wait states, back-to-back transfers and PSLVERR reporting.
// PARAMETERS
//  DATA_WIDTH      32  APB data width (PWDATA/PRDATA/cmd_wdata/rsp_rdata)
//  ADDR_WIDTH      16  APB address width (PADDR/cmd_addr)
//  TIMEOUT_CYCLES  16  max ACCESS cycles with PREADY=0 before abort (used only with APB_MST_TIMEOUT_EN)
// PORTS
//  PCLK       in   1           clock; all logic on rising edge
//  PRESETn    in   1           asynchronous active-low reset
//  cmd_valid  in   1           command request
//  cmd_ready  out  1           command accepted when cmd_valid&&cmd_ready
//  cmd_write  in   1           1=write, 0=read
//  cmd_addr   in   ADDR_WIDTH  transfer address
//  cmd_wdata  in   DATA_WIDTH  write data
//  rsp_valid  out  1           one-cycle response pulse; no backpressure
//  rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errored reads)
//  rsp_err    out  1           PSLVERR seen (or timeout) on this transfer
//  PSELx      out  1           APB select
//  PENABLE    out  1           APB enable
//  PWRITE     out  1           APB direction
//  PADDR      out  ADDR_WIDTH  APB address
//  PWDATA     out  DATA_WIDTH  APB write data
//  PRDATA     in   DATA_WIDTH  APB read data
//  PREADY     in   1           APB ready; wait states while 0
//  PSLVERR    in   1           APB error; tie 0 for slaves without it
// BEHAVIOUR
//  Reset: state IDLE; PSELx/PENABLE/PWRITE=0, PADDR/PWDATA=0, rsp_valid/rsp_err=0, rsp_rdata=0.
//   Reset mid-transfer aborts the transfer; no response is issued.
//  FSM states IDLE, SETUP, ACCESS:
//   IDLE: cmd_ready=1; on accept -> SETUP, latch addr/write/wdata into PADDR/PWRITE/PWDATA.
//   SETUP: PSELx=1, PENABLE=0; unconditional -> ACCESS.
//   ACCESS: PSELx=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable; PREADY=0 -> stay.
//    PREADY=1 -> complete. cmd_ready=1 in this cycle only.
//    If a command is accepted -> SETUP with new latch (PENABLE=0, PSELx stays 1); else -> IDLE (PSELx=0).
//   cmd_ready=0 in SETUP and in ACCESS with PREADY=0.
//  All APB outputs are registered and driven from state plus latched command.
//  Response: registered; rsp_valid=1 in the cycle after completion.
//   rsp_err=PSLVERR sampled at completion.
//   rsp_rdata=PRDATA for error-free reads; 0 otherwise.
//   rsp_valid=0 every other cycle; rsp_rdata/rsp_err hold last value.
//  Latency, zero-wait slave: accept edge N -> SETUP N+1 -> ACCESS N+2 -> rsp_valid N+3.
//   Each wait state adds one cycle.
//  Back-to-back throughput: one transfer per 2 cycles + wait states.
//  PRDATA/PSLVERR are sampled only when PSELx&&PENABLE&&PREADY.
// CONFIGURATION
//  APB_MST_TIMEOUT_EN defined:
//   Wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
//   Reaching TIMEOUT_CYCLES ends the transfer as if PREADY=1: rsp_err=1, rsp_rdata=0, next state IDLE.
//   A command is not accepted on the timeout cycle.
//  APB_MST_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES unused.
// STRUCTURE
//  shared_pkg gains:
//   typedef enum logic [1:0] {MST_IDLE, MST_SETUP, MST_ACCESS} apb_mst_state_e
//   typedef struct packed {write, addr, wdata} apb_cmd_t
//  Single module; no sub-module needed. Timeout counter sits inline under `ifdef.
// TESTING
//  Zero-wait write: cmd write 0x0040/0xDEADBEEF vs responder with PREADY=1
//   -> PADDR=0x0040, PWRITE=1, PENABLE high exactly 1 cycle; rsp_valid 3 cycles after accept; rsp_err=0.
//  Read through APB_Wrapper: write 0x0080=0xA5A5_0001 then read 0x0080
//   -> rsp_rdata=0xA5A5_0001; PADDR/PWRITE/PWDATA stable through all wait states.
//  Wait states: responder holds PREADY=0 for 3 ACCESS cycles
//   -> PENABLE high 4 cycles; cmd_ready=0 throughout; single rsp_valid pulse.
//  Back-to-back: cmd_valid held for 3 reads
//   -> PSELx never drops; SETUP/ACCESS alternate; 3 rsp_valid pulses in order.
//  Error: PSLVERR=1 with PREADY on a read -> rsp_err=1, rsp_rdata=0.
//  Reset mid-ACCESS (PRESETn low asynchronously)
//   -> PSELx/PENABLE=0 immediately; no rsp_valid; next command runs normally.
//  With APB_MST_TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY stuck 0
//   -> rsp_err=1 after 4 ACCESS cycles; FSM returns to IDLE.

Source files
------------

// File: rtl/apb_master_bridge_pkg.sv
// ---------------------------------------------------------------------------
// apb_master_bridge_pkg
// Shared types for the APB requester bridge:
//   apb_mst_state_e    - requester FSM states (IDLE / SETUP / ACCESS)
//   apb_cmd_t          - command word at the default bus widths
//   apb_mst_cnt_width  - width of a counter that must reach a given count - 1
// ---------------------------------------------------------------------------
package apb_master_bridge_pkg;

    localparam int APB_MST_DATA_W = 32;
    localparam int APB_MST_ADDR_W = 16;

    typedef enum logic [1:0] {
        MST_IDLE   = 2'd0,
        MST_SETUP  = 2'd1,
        MST_ACCESS = 2'd2
    } apb_mst_state_e;

    // Command word for bridges built at the default widths.
    typedef struct packed {
        logic                      write;
        logic [APB_MST_ADDR_W-1:0] addr;
        logic [APB_MST_DATA_W-1:0] wdata;
    } apb_cmd_t;

    // Bits needed to count 0 .. max_count-1 (at least one bit).
    function automatic int apb_mst_cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
// APB requester: converts a valid/ready command stream into APB SETUP/ACCESS
// transfers and returns exactly one response pulse per completed command.
//
// Optional feature macro: APB_MST_TIMEOUT_EN
//   defined   - an ACCESS phase that sees PREADY=0 for TIMEOUT_CYCLES cycles
//               is aborted and reported with rsp_err=1.
//   undefined - ACCESS waits for PREADY indefinitely.
//
// Ports
//   PCLK, PRESETn        clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_write/addr/wdata command fields, captured on accept
//   rsp_valid            one-cycle response pulse (no backpressure)
//   rsp_rdata/rsp_err    response payload, held between pulses
//   PSELx/PENABLE/PWRITE/PADDR/PWDATA  registered APB request outputs
//   PRDATA/PREADY/PSLVERR              APB completer inputs
// ---------------------------------------------------------------------------
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int DATA_WIDTH     = APB_MST_DATA_W,
    parameter int ADDR_WIDTH     = APB_MST_ADDR_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // Command latch sized by this instance's parameters.
    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    apb_mst_state_e        state_reg, state_next;
    cmd_t                  cmd_reg;
    logic                  psel_reg, penable_reg;
    logic                  rsp_valid_reg, rsp_err_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;

    logic accept;       // command handshake this cycle
    logic complete;     // current transfer ends this cycle (PREADY or abort)
    logic timeout_hit;  // abort of a stalled ACCESS this cycle

`ifdef APB_MST_TIMEOUT_EN
    localparam int                CNT_W    = apb_mst_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_reg;

    // Holding the counter at zero outside ACCESS is what clears it on every
    // entry to ACCESS, including back-to-back transfers through SETUP.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt_reg <= '0;
        end else if (state_reg != MST_ACCESS) begin
            wait_cnt_reg <= '0;
        end else if (!PREADY) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

    // The Nth stalled ACCESS cycle (count N-1 at its start) is the abort cycle.
    assign timeout_hit = (state_reg == MST_ACCESS) && !PREADY && (wait_cnt_reg == CNT_LAST);
`else
    // No watchdog: only a nonsensical negative limit could ever evaluate true,
    // so this is constant zero for every real configuration.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    // ---------------------------------------------------------------------
    // Next-state and handshake decode
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        complete   = 1'b0;
        case (state_reg)
            MST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = MST_SETUP;
                end
            end
            MST_SETUP: begin
                state_next = MST_ACCESS;
            end
            MST_ACCESS: begin
                if (PREADY) begin
                    // Completion cycle doubles as the accept slot so that
                    // back-to-back commands go straight to SETUP with PSELx high.
                    complete   = 1'b1;
                    cmd_ready  = 1'b1;
                    state_next = cmd_valid ? MST_SETUP : MST_IDLE;
                end else if (timeout_hit) begin
                    complete   = 1'b1;
                    state_next = MST_IDLE;
                end
            end
            default: begin
                state_next = MST_IDLE;
            end
        endcase
    end

    assign accept = cmd_valid && cmd_ready;

    // ---------------------------------------------------------------------
    // State, APB request outputs and command latch
    // PSELx/PENABLE are decoded from the next state so they are flops that
    // line up exactly with the state register.
    // ---------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg   <= MST_IDLE;
            psel_reg    <= 1'b0;
            penable_reg <= 1'b0;
            cmd_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            psel_reg    <= (state_next != MST_IDLE);
            penable_reg <= (state_next == MST_ACCESS);
            if (accept) begin
                cmd_reg.write <= cmd_write;
                cmd_reg.addr  <= cmd_addr;
                cmd_reg.wdata <= cmd_wdata;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Response register: PRDATA/PSLVERR are only looked at when PREADY ends
    // the ACCESS phase; an aborted transfer reports an error with zero data.
    // ---------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            rsp_valid_reg <= complete;
            if (complete) begin
                if (PREADY) begin
                    rsp_err_reg   <= PSLVERR;
                    rsp_rdata_reg <= (!cmd_reg.write && !PSLVERR) ? PRDATA : '0;
                end else begin
                    rsp_err_reg   <= 1'b1;
                    rsp_rdata_reg <= '0;
                end
            end
        end
    end

    assign PSELx     = psel_reg;
    assign PENABLE   = penable_reg;
    assign PWRITE    = cmd_reg.write;
    assign PADDR     = cmd_reg.addr;
    assign PWDATA    = cmd_reg.wdata;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
// Directed bench for apb_master_bridge with a small APB completer model
// (memory, programmable wait states, error injection). Expected responses
// are queued at issue time and popped by a monitor on every rsp_valid.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSELx, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    // ------------------------------------------------------------------
    // APB completer model
    // ------------------------------------------------------------------
    logic [DW-1:0] mem [0:1023];
    int            wait_target = 0;
    bit            err_inject = 1'b0;
    int            wcnt;
    logic          in_access;

    assign in_access = PSELx && PENABLE;
    assign PREADY    = in_access && (wcnt >= wait_target);
    assign PRDATA    = PREADY ? mem[PADDR[9:0]] : 32'hDEAD_0BAD;
    assign PSLVERR   = in_access && err_inject;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wcnt <= 0;
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (in_access && !PREADY) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
            if (PREADY && PWRITE && !err_inject) mem[PADDR[9:0]] <= PWDATA;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard and checking
    // ------------------------------------------------------------------
    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    int            rsp_cnt = 0, last_rsp_cyc = 0, penable_cnt = 0;
    int            ready_bad = 0, stab_bad = 0, psel_falls = 0, psel_cycles = 0;
    logic          psel_d = 1'b0;
    logic [AW-1:0] s_addr = '0;
    logic          s_write = 1'b0;
    logic [DW-1:0] s_wdata = '0;

    always @(negedge PCLK) begin
        if (PRESETn) begin
            if (PENABLE) penable_cnt++;
            if (PSELx) psel_cycles++;
            if (psel_d && !PSELx) psel_falls++;
            psel_d = PSELx;
            if (PSELx && !PENABLE) begin
                s_addr  = PADDR;
                s_write = PWRITE;
                s_wdata = PWDATA;
            end
            if (PSELx && PENABLE && (PADDR !== s_addr || PWRITE !== s_write || PWDATA !== s_wdata))
                stab_bad++;
            if (cmd_ready && PSELx && !(PENABLE && PREADY)) ready_bad++;
            if (rsp_valid) begin
                exp_t e;
                rsp_cnt++;
                last_rsp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid with err=%0b rdata=0x%0h, expected none", rsp_err, rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    $display("rsp #%0d: err=%0b rdata=0x%08h (cycle %0d)", rsp_cnt, rsp_err, rsp_rdata, cyc);
                end
            end
        end else begin
            psel_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    int accept_cyc = 0;

    // Presents a command and returns just after the accepting edge; cmd_valid
    // is left high so a following send() forms a back-to-back stream.
    task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input bit push, input logic e_err, input logic [DW-1:0] e_rdata);
        exp_t e;
        int   n;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        if (push) begin
            e.err   = e_err;
            e.rdata = e_rdata;
            exp_q.push_back(e);
        end
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got cmd_ready=0 for %0d cycles, expected acceptance", n);
        end
        accept_cyc = cyc;
        $display("cmd %s addr=0x%04h wdata=0x%08h accepted (cycle %0d)", wr ? "WR" : "RD", addr, wdata, cyc);
        @(posedge PCLK);
    endtask

    task automatic idle();
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge PCLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge PCLK);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int a1, a2, a3, snap, n;

        // Reset values
        repeat (3) @(negedge PCLK);
        check("rst_psel", 64'(PSELx), 64'd0);
        check("rst_penable", 64'(PENABLE), 64'd0);
        check("rst_pwrite", 64'(PWRITE), 64'd0);
        check("rst_paddr", 64'(PADDR), 64'd0);
        check("rst_pwdata", 64'(PWDATA), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // Zero-wait write
        wait_target = 0;
        penable_cnt = 0;
        send(1'b1, 16'h0040, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        idle();
        wait_rsp();
        check("zw_paddr", 64'(s_addr), 64'h0040);
        check("zw_pwrite", 64'(s_write), 64'd1);
        check("zw_pwdata", 64'(s_wdata), 64'hDEAD_BEEF);
        check("zw_penable_cycles", 64'(penable_cnt), 64'd1);
        check("zw_latency", 64'(last_rsp_cyc - accept_cyc), 64'd3);

        // Write then read back through two wait states
        wait_target = 2;
        send(1'b1, 16'h0080, 32'hA5A5_0001, 1'b1, 1'b0, 32'h0);
        idle();
        send(1'b0, 16'h0080, 32'h0, 1'b1, 1'b0, 32'hA5A5_0001);
        idle();
        wait_rsp();

        // Three wait states: PENABLE for 4 cycles, one pulse
        wait_target = 3;
        penable_cnt = 0;
        snap = rsp_cnt;
        send(1'b0, 16'h0040, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        idle();
        wait_rsp();
        check("ws_penable_cycles", 64'(penable_cnt), 64'd4);
        check("ws_latency", 64'(last_rsp_cyc - accept_cyc), 64'd6);
        check("ws_rsp_pulses", 64'(rsp_cnt - snap), 64'd1);

        // Back-to-back reads
        wait_target = 0;
        psel_cycles = 0;
        psel_falls = 0;
        send(1'b0, 16'h0040, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        a1 = accept_cyc;
        send(1'b0, 16'h0080, 32'h0, 1'b1, 1'b0, 32'hA5A5_0001);
        a2 = accept_cyc;
        send(1'b0, 16'h0100, 32'h0, 1'b1, 1'b0, 32'h0);
        a3 = accept_cyc;
        idle();
        wait_rsp();
        check("b2b_accept_gap1", 64'(a2 - a1), 64'd2);
        check("b2b_accept_gap2", 64'(a3 - a2), 64'd2);
        check("b2b_psel_cycles", 64'(psel_cycles), 64'd6);
        check("b2b_psel_falls", 64'(psel_falls), 64'd1);

        // Slave error on read and on write; errored write must not land
        err_inject = 1'b1;
        wait_target = 1;
        send(1'b0, 16'h0080, 32'h0, 1'b1, 1'b1, 32'h0);
        idle();
        send(1'b1, 16'h0080, 32'h1111_2222, 1'b1, 1'b1, 32'h0);
        idle();
        wait_rsp();
        err_inject = 1'b0;
        send(1'b0, 16'h0080, 32'h0, 1'b1, 1'b0, 32'hA5A5_0001);
        idle();
        wait_rsp();

        // Asynchronous reset in the middle of a long ACCESS phase
        wait_target = 10;
        snap = rsp_cnt;
        send(1'b0, 16'h0040, 32'h0, 1'b0, 1'b0, 32'h0);
        idle();
        n = 0;
        while (!PENABLE && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        check("mid_rst_in_access", 64'(PENABLE), 64'd1);
        repeat (2) @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1;
        check("mid_rst_psel", 64'(PSELx), 64'd0);
        check("mid_rst_penable", 64'(PENABLE), 64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (4) @(negedge PCLK);
        check("mid_rst_no_rsp", 64'(rsp_cnt - snap), 64'd0);
        wait_target = 0;
        send(1'b1, 16'h0044, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
        idle();
        send(1'b0, 16'h0044, 32'h0, 1'b1, 1'b0, 32'h1234_5678);
        idle();
        wait_rsp();

`ifdef APB_MST_TIMEOUT_EN
        // Completer never ready: abort after TO stalled ACCESS cycles
        wait_target = 1000;
        penable_cnt = 0;
        send(1'b0, 16'h0040, 32'h0, 1'b1, 1'b1, 32'h0);
        idle();
        wait_rsp();
        check("to_penable_cycles", 64'(penable_cnt), 64'(TO));
        check("to_latency", 64'(last_rsp_cyc - accept_cyc), 64'(TO + 2));
        check("to_back_idle_psel", 64'(PSELx), 64'd0);
        check("to_back_idle_ready", 64'(cmd_ready), 64'd1);
        wait_target = 0;
`endif

        check("addr_ctrl_stable", 64'(stab_bad), 64'd0);
        check("cmd_ready_busy", 64'(ready_bad), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
